// File: rtl/vga_pkg.sv
// Shared VGA raster timing constants and helpers for the timing, tile map
// and sprite stages.
package vga_pkg;

   // Default 640x480@60 timing with a 25 MHz pixel rate from a 50 MHz clock.
   localparam int DEF_CLK_DIV = 2;
   localparam int DEF_H_VIS   = 640;
   localparam int DEF_H_FP    = 16;
   localparam int DEF_H_SYNC  = 96;
   localparam int DEF_H_BP    = 48;
   localparam int DEF_V_VIS   = 480;
   localparam int DEF_V_FP    = 10;
   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BP    = 33;

   // Default Donkey Kong play-field rectangle, inclusive bounds.
   localparam int DEF_PLAY_X0 = 150;
   localparam int DEF_PLAY_X1 = 489;
   localparam int DEF_PLAY_Y0 = 20;
   localparam int DEF_PLAY_Y1 = 469;

   // Raster counters are 10 bits wide, so a line or frame may not exceed this.
   localparam int CNT_W     = 10;
   localparam int CNT_LIMIT = 1024;

   // Decoded per-pixel flags, registered alongside the counters.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank_n;
      logic bounds_draw;
      logic line_start;
      logic frame_start;
   } raster_flags_t;

   localparam raster_flags_t FLAGS_RESET = '{
      hsync:       1'b1,
      vsync:       1'b1,
      blank_n:     1'b0,
      bounds_draw: 1'b0,
      line_start:  1'b0,
      frame_start: 1'b0
   };

   function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

   function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

endpackage

// File: rtl/pix_div.sv
// Pixel-enable divider: one-clock strobe every CLK_DIV board clocks.
// With CLK_DIV=1 the strobe is held high continuously once out of reset.
module pix_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic pix_en
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             pix_en_q;
   logic             pix_en_d;

   if (CLK_DIV < 1) begin : g_div_chk
      $error("pix_div: CLK_DIV must be at least 1");
   end

   // Next divider count; strobe fires on the clock after the count reaches its last value.
   always_comb begin
      if (div_q == DIV_LAST) begin
         div_d = {DIV_W{1'b0}};
      end else begin
         div_d = div_q + DIV_W'(1);
      end
      pix_en_d = (div_q == DIV_LAST);
   end

   // Divider and strobe registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q    <= {DIV_W{1'b0}};
         pix_en_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         pix_en_q <= pix_en_d;
      end
   end

   assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: h/v counters advancing on the pixel strobe, with
// sync, visible-area, play-field and line/frame-start flags registered from
// the next counter values so they line up with hcount/vcount.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int H_VIS   = DEF_H_VIS,
   parameter int H_FP    = DEF_H_FP,
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BP    = DEF_H_BP,
   parameter int V_VIS   = DEF_V_VIS,
   parameter int V_FP    = DEF_V_FP,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BP    = DEF_V_BP,
   parameter int PLAY_X0 = DEF_PLAY_X0,
   parameter int PLAY_X1 = DEF_PLAY_X1,
   parameter int PLAY_Y0 = DEF_PLAY_Y0,
   parameter int PLAY_Y1 = DEF_PLAY_Y1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_en,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       bounds_draw,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = h_total(H_VIS, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_VIS, V_FP, V_SYNC, V_BP);

   // Comparisons run at 11 bits so a boundary equal to the counter limit still fits.
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);
   localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
   localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
   localparam logic [10:0] PX0      = 11'(PLAY_X0);
   localparam logic [10:0] PX1      = 11'(PLAY_X1);
   localparam logic [10:0] PY0      = 11'(PLAY_Y0);
   localparam logic [10:0] PY1      = 11'(PLAY_Y1);

   if (H_TOTAL > CNT_LIMIT) begin : g_h_total_chk
      $error("vga_timing: H_TOTAL exceeds the 10-bit counter range");
   end
   if (V_TOTAL > CNT_LIMIT) begin : g_v_total_chk
      $error("vga_timing: V_TOTAL exceeds the 10-bit counter range");
   end

   logic          pix_en_s;
   logic [9:0]    hcount_q;
   logic [9:0]    hcount_d;
   logic [9:0]    vcount_q;
   logic [9:0]    vcount_d;
   raster_flags_t flags_q;
   raster_flags_t flags_d;
   logic [10:0]   h_x_s;
   logic [10:0]   v_x_s;
   logic          blank_next_s;

   pix_div #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .pix_en (pix_en_s)
   );

   // Next raster position: advance on the strobe, wrapping the line and the frame.
   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (pix_en_s) begin
         if ({1'b0, hcount_q} == H_LAST) begin
            hcount_d = 10'd0;
            if ({1'b0, vcount_q} == V_LAST) begin
               vcount_d = 10'd0;
            end else begin
               vcount_d = vcount_q + 10'd1;
            end
         end else begin
            hcount_d = hcount_q + 10'd1;
            vcount_d = vcount_q;
         end
      end else begin
         hcount_d = hcount_q;
         vcount_d = vcount_q;
      end
   end

   assign h_x_s        = {1'b0, hcount_d};
   assign v_x_s        = {1'b0, vcount_d};
   assign blank_next_s = (h_x_s < H_VIS_W) && (v_x_s < V_VIS_W);

   // Decode flags for the position being loaded; start pulses last one clock only.
   always_comb begin
      flags_d = flags_q;
      if (pix_en_s) begin
         flags_d.hsync       = ~((h_x_s >= HS_START) && (h_x_s < HS_END));
         flags_d.vsync       = ~((v_x_s >= VS_START) && (v_x_s < VS_END));
         flags_d.blank_n     = blank_next_s;
         flags_d.bounds_draw = blank_next_s &&
                               (h_x_s >= PX0) && (h_x_s <= PX1) &&
                               (v_x_s >= PY0) && (v_x_s <= PY1);
         flags_d.line_start  = (hcount_d == 10'd0);
         flags_d.frame_start = (hcount_d == 10'd0) && (vcount_d == 10'd0);
      end else begin
         flags_d.line_start  = 1'b0;
         flags_d.frame_start = 1'b0;
      end
   end

   // Counter and flag registers; reset wins over the strobe at any clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcount_q <= 10'd0;
         vcount_q <= 10'd0;
         flags_q  <= FLAGS_RESET;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         flags_q  <= flags_d;
      end
   end

   assign pix_en      = pix_en_s;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hsync       = flags_q.hsync;
   assign vsync       = flags_q.vsync;
   assign blank_n     = flags_q.blank_n;
   assign bounds_draw = flags_q.bounds_draw;
   assign line_start  = flags_q.line_start;
   assign frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance (CLK_DIV=2) and a small
// CLK_DIV=1 raster that reaches frame wraps and play-field corners quickly.
// Expected outputs come from a closed-form model indexed by clocks since reset.
module tb_vga_timing;

   typedef struct packed {
      int d;
      int hvis, hfp, hs, hbp;
      int vvis, vfp, vs, vbp;
      int px0, px1, py0, py1;
   } tp_t;

   typedef struct packed {
      bit pix_en;
      int h;
      int v;
      bit hsync, vsync, blank_n, bounds, ls, fs;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;

   logic       pe_a, hs_a, vs_a, bn_a, bd_a, ls_a, fs_a;
   logic [9:0] hc_a, vc_a;
   logic       pe_b, hs_b, vs_b, bn_b, bd_b, ls_b, fs_b;
   logic [9:0] hc_b, vc_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   k_a      = -1;
   int   k_b      = -1;
   tp_t  pa;
   tp_t  pb;

   always #10 clk = ~clk;

   vga_timing u_a (
      .clk(clk), .rst_n(rst_a), .pix_en(pe_a), .hcount(hc_a), .vcount(vc_a),
      .hsync(hs_a), .vsync(vs_a), .blank_n(bn_a), .bounds_draw(bd_a),
      .line_start(ls_a), .frame_start(fs_a)
   );

   vga_timing #(
      .CLK_DIV(1), .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .PLAY_X0(4), .PLAY_X1(11), .PLAY_Y0(2), .PLAY_Y1(7)
   ) u_b (
      .clk(clk), .rst_n(rst_b), .pix_en(pe_b), .hcount(hc_b), .vcount(vc_b),
      .hsync(hs_b), .vsync(vs_b), .blank_n(bn_b), .bounds_draw(bd_b),
      .line_start(ls_b), .frame_start(fs_b)
   );

   // Outputs after k clock edges with reset released (k=0: reset edge).
   // Pixel strobes are high after every d-th edge; pixel index P counts strobes consumed.
   function automatic exp_t model(input tp_t p, input int k);
      exp_t e;
      int   ht, vt, pp, hs0, vs0;
      ht = p.hvis + p.hfp + p.hs + p.hbp;
      vt = p.vvis + p.vfp + p.vs + p.vbp;
      e = '0;
      e.hsync = 1'b1;
      e.vsync = 1'b1;
      if (k > 0) begin
         e.pix_en = ((k % p.d) == 0);
         if (k > p.d) begin
            pp  = (k - 1) / p.d;
            e.h = pp % ht;
            e.v = (pp / ht) % vt;
            hs0 = p.hvis + p.hfp;
            vs0 = p.vvis + p.vfp;
            e.hsync   = !(e.h >= hs0 && e.h < hs0 + p.hs);
            e.vsync   = !(e.v >= vs0 && e.v < vs0 + p.vs);
            e.blank_n = (e.h < p.hvis) && (e.v < p.vvis);
            e.bounds  = e.blank_n && e.h >= p.px0 && e.h <= p.px1 && e.v >= p.py0 && e.v <= p.py1;
            e.ls      = (((k - 1) % p.d) == 0) && (e.h == 0);
            e.fs      = e.ls && (e.v == 0);
         end
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_inst(input string tag, input exp_t e, input logic pe,
                           input logic [9:0] h, input logic [9:0] v, input logic hs,
                           input logic vs, input logic bn, input logic bd,
                           input logic ls, input logic fs);
      chk({tag, "_pix_en"}, {31'd0, pe}, e.pix_en);
      chk({tag, "_hcount"}, {22'd0, h}, e.h);
      chk({tag, "_vcount"}, {22'd0, v}, e.v);
      chk({tag, "_hsync"}, {31'd0, hs}, e.hsync);
      chk({tag, "_vsync"}, {31'd0, vs}, e.vsync);
      chk({tag, "_blank_n"}, {31'd0, bn}, e.blank_n);
      chk({tag, "_bounds_draw"}, {31'd0, bd}, e.bounds);
      chk({tag, "_line_start"}, {31'd0, ls}, e.ls);
      chk({tag, "_frame_start"}, {31'd0, fs}, e.fs);
   endtask

   // Clock edges since the last edge that sampled reset.
   always @(posedge clk) begin
      k_a <= (rst_a == 1'b0) ? 0 : ((k_a < 0) ? -1 : k_a + 1);
      k_b <= (rst_b == 1'b0) ? 0 : ((k_b < 0) ? -1 : k_b + 1);
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (k_a >= 0) cmp_inst("A", model(pa, k_a), pe_a, hc_a, vc_a, hs_a, vs_a, bn_a, bd_a, ls_a, fs_a);
      if (k_b >= 0) cmp_inst("B", model(pb, k_b), pe_b, hc_b, vc_b, hs_b, vs_b, bn_b, bd_b, ls_b, fs_b);
   end

   task automatic wait_k(input bit sel_b, input int target);
      int guard;
      guard = 0;
      while (((sel_b ? k_b : k_a) < target) && guard < 60000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 60000) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_k timeout: k=%0d, required %0d", sel_b ? k_b : k_a, target);
      end
   endtask

   task automatic seq_a();
      int lows, extra_ls;
      wait_k(1'b0, 1);    chk("a_k1_pix_en", {31'd0, pe_a}, 0);
      wait_k(1'b0, 2);    chk("a_k2_pix_en", {31'd0, pe_a}, 1);
                          chk("a_k2_hcount", {22'd0, hc_a}, 0);
                          chk("a_k2_blank_n", {31'd0, bn_a}, 0);
      wait_k(1'b0, 3);    chk("a_k3_hcount", {22'd0, hc_a}, 1);
                          chk("a_k3_vcount", {22'd0, vc_a}, 0);
                          chk("a_k3_blank_n", {31'd0, bn_a}, 1);
                          chk("a_k3_frame_start", {31'd0, fs_a}, 0);
      wait_k(1'b0, 1311); chk("a_h655_hsync", {31'd0, hs_a}, 1);
      wait_k(1'b0, 1313); chk("a_h656_hcount", {22'd0, hc_a}, 656);
                          chk("a_h656_hsync", {31'd0, hs_a}, 0);
      wait_k(1'b0, 1503); chk("a_h751_hsync", {31'd0, hs_a}, 0);
      wait_k(1'b0, 1505); chk("a_h752_hsync", {31'd0, hs_a}, 1);
      wait_k(1'b0, 1601); chk("a_line1_start", {31'd0, ls_a}, 1);
      lows = 0;
      extra_ls = 0;
      while (k_a < 3201 && k_a > 0) begin
         @(negedge clk);
         if (hs_a == 1'b0) lows++;
         if (ls_a == 1'b1 && k_a < 3201) extra_ls++;
      end
      chk("a_line2_start", {31'd0, ls_a}, 1);
      chk("a_line_start_between", extra_ls, 0);
      chk("a_hsync_low_clks", lows, 192);
      wait_k(1'b0, 4601); chk("a_pre_rst_hcount", {22'd0, hc_a}, 700);
                          chk("a_pre_rst_vcount", {22'd0, vc_a}, 2);
                          chk("a_pre_rst_hsync", {31'd0, hs_a}, 0);
      rst_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      chk("a_rst_hcount", {22'd0, hc_a}, 0);
      chk("a_rst_vcount", {22'd0, vc_a}, 0);
      chk("a_rst_hsync", {31'd0, hs_a}, 1);
      chk("a_rst_blank_n", {31'd0, bn_a}, 0);
      wait_k(1'b0, 2);     chk("a_re_k2_pix_en", {31'd0, pe_a}, 1);
      wait_k(1'b0, 3);     chk("a_re_k3_hcount", {22'd0, hc_a}, 1);
      wait_k(1'b0, 30701); chk("a_150_19_vcount", {22'd0, vc_a}, 19);
                           chk("a_150_19_bounds", {31'd0, bd_a}, 0);
      wait_k(1'b0, 32299); chk("a_149_20_hcount", {22'd0, hc_a}, 149);
                           chk("a_149_20_bounds", {31'd0, bd_a}, 0);
      wait_k(1'b0, 32301); chk("a_150_20_bounds", {31'd0, bd_a}, 1);
   endtask

   task automatic seq_b();
      wait_k(1'b1, 1);   chk("b_k1_pix_en", {31'd0, pe_b}, 1);
                         chk("b_k1_blank_n", {31'd0, bn_b}, 0);
      wait_k(1'b1, 2);   chk("b_k2_hcount", {22'd0, hc_b}, 1);
                         chk("b_k2_pix_en", {31'd0, pe_b}, 1);
      wait_k(1'b1, 19);  chk("b_h18_hsync", {31'd0, hs_b}, 0);
      wait_k(1'b1, 25);  chk("b_line1_start", {31'd0, ls_b}, 1);
      wait_k(1'b1, 26);  chk("b_line1_start_end", {31'd0, ls_b}, 0);
      wait_k(1'b1, 29);  chk("b_4_1_bounds", {31'd0, bd_b}, 0);
      wait_k(1'b1, 49);  chk("b_line2_start", {31'd0, ls_b}, 1);
      wait_k(1'b1, 52);  chk("b_3_2_bounds", {31'd0, bd_b}, 0);
      wait_k(1'b1, 53);  chk("b_4_2_bounds", {31'd0, bd_b}, 1);
      wait_k(1'b1, 180); chk("b_11_7_bounds", {31'd0, bd_b}, 1);
      wait_k(1'b1, 181); chk("b_12_7_bounds", {31'd0, bd_b}, 0);
      wait_k(1'b1, 197); chk("b_4_8_bounds", {31'd0, bd_b}, 0);
      wait_k(1'b1, 241); chk("b_v10_blank_n", {31'd0, bn_b}, 0);
      wait_k(1'b1, 265); chk("b_v11_vsync", {31'd0, vs_b}, 1);
      wait_k(1'b1, 289); chk("b_v12_vsync", {31'd0, vs_b}, 0);
      wait_k(1'b1, 313); chk("b_v13_vsync", {31'd0, vs_b}, 0);
      wait_k(1'b1, 337); chk("b_v14_vsync", {31'd0, vs_b}, 1);
      wait_k(1'b1, 408); chk("b_last_hcount", {22'd0, hc_b}, 23);
                         chk("b_last_vcount", {22'd0, vc_b}, 16);
      wait_k(1'b1, 409); chk("b_wrap_hcount", {22'd0, hc_b}, 0);
                         chk("b_wrap_vcount", {22'd0, vc_b}, 0);
                         chk("b_wrap_line_start", {31'd0, ls_b}, 1);
                         chk("b_wrap_frame_start", {31'd0, fs_b}, 1);
      wait_k(1'b1, 817); chk("b_wrap2_frame_start", {31'd0, fs_b}, 1);
   endtask

   initial begin
      pa = '{d: 2, hvis: 640, hfp: 16, hs: 96, hbp: 48, vvis: 480, vfp: 10, vs: 2, vbp: 33,
             px0: 150, px1: 489, py0: 20, py1: 469};
      pb = '{d: 1, hvis: 16, hfp: 2, hs: 3, hbp: 3, vvis: 10, vfp: 2, vs: 2, vbp: 3,
             px0: 4, px1: 11, py0: 2, py1: 7};
      // Hand-computed points that pin the model itself.
      chk("model_a_first_strobe", {31'd0, model(pa, 2).pix_en}, 1);
      chk("model_a_656_hsync", {31'd0, model(pa, 1313).hsync}, 0);
      chk("model_a_150_20_bounds", {31'd0, model(pa, 32301).bounds}, 1);
      chk("model_b_wrap_frame_start", {31'd0, model(pb, 409).fs}, 1);
      chk("model_b_491_vcount", model(pb, 313).v, 13);
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (5) @(negedge clk);
      chk("a_in_reset_hsync", {31'd0, hs_a}, 1);
      chk("a_in_reset_pix_en", {31'd0, pe_a}, 0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      fork
         seq_a();
         seq_b();
      join
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
